// File: rtl/imm_gen_pkg.sv
// Shared RV32I opcode constants and immediate format codes for the decode stage.
package imm_gen_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_t;

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational opcode-to-format decode and sign-extended immediate assembly.
module imm_decode_comb
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_instr,
  output logic [XLEN-1:0] o_imm,
  output imm_type_t       o_type
);

  logic w_sign;
  assign w_sign = i_instr[31];

  always_comb begin
    o_type = IMM_NONE;
    o_imm  = '0;
    case (i_instr[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
        o_type = IMM_I;
        o_imm  = {{20{w_sign}}, i_instr[31:20]};
      end
      OPC_STORE: begin
        o_type = IMM_S;
        o_imm  = {{20{w_sign}}, i_instr[31:25], i_instr[11:7]};
      end
      OPC_BRANCH: begin
        o_type = IMM_B;
        o_imm  = {{19{w_sign}}, i_instr[31], i_instr[7], i_instr[30:25],
                  i_instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        o_type = IMM_U;
        o_imm  = {i_instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        o_type = IMM_J;
        o_imm  = {{11{w_sign}}, i_instr[31], i_instr[19:12], i_instr[20],
                  i_instr[30:21], 1'b0};
      end
      // OP (R-type) and unknown opcodes carry no immediate
      default: begin
        o_type = IMM_NONE;
        o_imm  = '0;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen.sv
// Registered immediate generator: one-cycle latency, stall holds all outputs.
module imm_gen
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] instr,
  input  logic            valid_i,
  input  logic            stall_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      imm_type_o,
  output logic            imm_valid_o
);

  logic [XLEN-1:0] w_imm;
  imm_type_t       w_type;
  logic [XLEN-1:0] r_imm;
  logic [2:0]      r_type;
  logic            r_vld;

  imm_decode_comb #(.XLEN(XLEN)) u_dec (
    .i_instr (instr),
    .o_imm   (w_imm),
    .o_type  (w_type)
  );

  // Immediate and type load even when invalid; only the valid flag gates use.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_imm  <= '0;
      r_type <= 3'd0;
      r_vld  <= 1'b0;
    end else if (!stall_i) begin
      r_imm  <= w_imm;
      r_type <= w_type;
      r_vld  <= valid_i;
    end
  end

  assign imm_o       = r_imm;
  assign imm_type_o  = r_type;
  assign imm_valid_o = r_vld;

endmodule

// File: tb/tb_imm_gen.sv
// Directed and randomized check of imm_gen against an arithmetic reference model.
module tb_imm_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        valid_i = 1'b0;
  logic        stall_i = 1'b0;
  logic [31:0] imm_o;
  logic [2:0]  imm_type_o;
  logic        imm_valid_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_imm = '0;
  int          m_type = 0;
  logic        m_vld = 1'b0;

  imm_gen #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .valid_i     (valid_i),
    .stall_i     (stall_i),
    .imm_o       (imm_o),
    .imm_type_o  (imm_type_o),
    .imm_valid_o (imm_valid_o)
  );

  always #5 clk = ~clk;

  function automatic int ref_type(logic [31:0] w);
    case (w & 32'h7f)
      32'h13, 32'h03, 32'h67, 32'h73: return 1;
      32'h23:                         return 2;
      32'h63:                         return 3;
      32'h37, 32'h17:                 return 4;
      32'h6f:                         return 5;
      default:                        return 0;
    endcase
  endfunction

  // Field arithmetic: sum of weighted fields, sign bit weighted negatively.
  function automatic logic [31:0] ref_imm(logic [31:0] w);
    int v;
    int neg;
    neg = (w >> 31) & 1;
    case (ref_type(w))
      1: v = int'((w >> 20) & 32'hfff) - neg * 4096;
      2: v = int'((((w >> 25) & 32'h7f) << 5) + ((w >> 7) & 32'h1f)) - neg * 4096;
      3: v = int'((((w >> 7) & 1) << 11) + (((w >> 25) & 32'h3f) << 5)
                 + (((w >> 8) & 32'hf) << 1)) - neg * 4096;
      4: v = int'(w & 32'hfffff000);
      5: v = int'((((w >> 12) & 32'hff) << 12) + (((w >> 20) & 1) << 11)
                 + (((w >> 21) & 32'h3ff) << 1)) - neg * (1 << 20);
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".imm"},  imm_o, m_imm);
    check({tag, ".type"}, {29'd0, imm_type_o}, 32'(m_type));
    check({tag, ".vld"},  {31'd0, imm_valid_o}, {31'd0, m_vld});
  endtask

  // Apply one cycle of input, advance the model, compare just after the edge.
  task automatic step(input logic [31:0] w, input logic v, input logic s, input string tag);
    @(negedge clk);
    instr = w; valid_i = v; stall_i = s;
    @(posedge clk);
    if (!s) begin
      m_imm = ref_imm(w); m_type = ref_type(w); m_vld = v;
    end
    #1;
    check_model(tag);
  endtask

  task automatic dir(input logic [31:0] w, input logic [31:0] eimm, input int etype, input string tag);
    step(w, 1'b1, 1'b0, tag);
    check({tag, ".const_imm"},  imm_o, eimm);
    check({tag, ".const_type"}, {29'd0, imm_type_o}, 32'(etype));
  endtask

  logic [6:0] opcs [11] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63,
                           7'h37, 7'h17, 7'h6f, 7'h33, 7'h7f};

  initial begin
    #2;
    check_model("reset");
    @(posedge clk); #1;
    check_model("reset_held");
    @(negedge clk); rst = 1'b0;

    dir(32'hf9c30293, 32'hFFFFFF9C, 1, "addi_m100");
    dir(32'h06430293, 32'h00000064, 1, "addi_p100");
    dir(32'h0c832283, 32'h000000C8, 1, "lw_p200");
    dir(32'hf3832283, 32'hFFFFFF38, 1, "lw_m200");
    dir(32'hFE532E23, 32'hFFFFFFFC, 2, "sw_m4");
    dir(32'h00628863, 32'h00000010, 3, "beq_p16");
    dir(32'h123452B7, 32'h12345000, 4, "lui");
    dir(32'hFFDFF0EF, 32'hFFFFFFFC, 5, "jal_m4");
    dir(32'h00628033, 32'h00000000, 0, "add");
    dir(32'hFFFFFFFF, 32'h00000000, 0, "opc_7f");

    dir(32'h80000013, 32'hFFFFF800, 1, "addi_min");
    step(32'h123452B7, 1'b1, 1'b1, "stall1");
    check("stall1.const_imm", imm_o, 32'hFFFFF800);
    step(32'hFFDFF0EF, 1'b0, 1'b1, "stall2");
    check("stall2.const_vld", {31'd0, imm_valid_o}, 32'd1);
    step(32'h06430293, 1'b0, 1'b0, "novalid");
    check("novalid.const_vld", {31'd0, imm_valid_o}, 32'd0);

    dir(32'h123452B7, 32'h12345000, 4, "pre_rst");
    @(negedge clk); #2;
    rst = 1'b1; valid_i = 1'b1; instr = 32'hFFDFF0EF;
    m_imm = '0; m_type = 0; m_vld = 1'b0;
    #1;
    check_model("rst_async");
    @(posedge clk); #1;
    check_model("rst_hold");
    @(negedge clk); rst = 1'b0;
    dir(32'hFE532E23, 32'hFFFFFFFC, 2, "post_rst");

    for (int i = 0; i < 300; i++) begin
      logic [31:0] r;
      r = $urandom;
      r[6:0] = opcs[$urandom_range(0, 10)];
      step(r, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
